// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state and transaction owner encodings
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, one-hot grant, last-grant memory
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);
  owner_t r_last;
  always_comb o_gnt = &i_req ? (r_last == OWN_DATA ? 2'b01 : 2'b10) : i_req;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_last <= OWN_INST;
    else if (i_en && |i_req) r_last <= o_gnt[1] ? OWN_DATA : OWN_INST;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory channel between fetch and load/store ports
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);
  state_t                r_state;
  owner_t                r_owner;
  logic                  r_wr;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [1:0]            w_gnt;
  logic                  w_idle;
  logic                  w_rsp;
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req ({data_req, inst_req}),
    .i_en  (w_idle),
    .o_gnt (w_gnt)
  );
  // addr_ok and rdata are combinational, so they are masked while reset is held
  always_comb begin
    w_idle       = r_state == IDLE && !reset;
    w_rsp        = r_state == RESP && mem_data_ok;
    inst_addr_ok = w_idle && w_gnt[0];
    data_addr_ok = w_idle && w_gnt[1];
    inst_data_ok = w_rsp && r_owner == OWN_INST;
    data_data_ok = w_rsp && r_owner == OWN_DATA;
    inst_rdata   = reset ? '0 : mem_rdata;
    data_rdata   = reset ? '0 : mem_rdata;
    mem_req      = r_state == REQ;
    mem_wr       = r_wr;
    mem_wstrb    = r_wstrb;
    mem_addr     = r_addr;
    mem_wdata    = r_wdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= OWN_INST;
      r_wr    <= 1'b0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_idle && |w_gnt) begin
      r_state <= REQ;
      r_owner <= w_gnt[1] ? OWN_DATA : OWN_INST;
      r_wr    <= w_gnt[1] && data_wr;
      r_wstrb <= w_gnt[1] ? data_wstrb : '0;
      r_addr  <= w_gnt[1] ? data_addr : inst_addr;
      r_wdata <= w_gnt[1] ? data_wdata : '0;
    end else if (r_state == REQ && mem_addr_ok) r_state <= RESP;
    else if (r_state == RESP && mem_data_ok) r_state <= IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam logic [31:0] K = 32'h1E80_0C0C;
  typedef struct packed {logic own; logic wr; logic [3:0] wstrb; logic [31:0] addr; logic [31:0] wdata;} mexp_t;
  typedef struct packed {logic own; logic [31:0] rdata;} rexp_t;
  logic clk = 0, reset = 0;
  logic inst_req = 0, data_req = 0, data_wr = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0;
  logic [3:0] data_wstrb = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic mem_req, mem_wr;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  int errors = 0, checks = 0;
  int bp_fix = 0, dl_fix = 0;
  bit rnd_stray = 0, force_stray = 0, real_resp = 0;
  mexp_t mem_q[$];
  rexp_t rsp_q[$];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: bounded accept/response delays, read data is address ^ K
  initial begin
    int phase, bp, dl;
    logic [31:0] acc_addr;
    phase = 0; bp = 0; dl = 0; acc_addr = 0;
    forever begin
      @(posedge clk); #2;
      mem_addr_ok = 0; mem_data_ok = force_stray; real_resp = 0; mem_rdata = $urandom;
      if (reset) phase = 0;
      else begin
        if (phase == 0 && mem_req) begin
          phase = 1;
          bp = bp_fix >= 0 ? bp_fix : $urandom_range(0, 3);
        end
        if (phase == 1) begin
          if (bp == 0) begin
            mem_addr_ok = 1; acc_addr = mem_addr; phase = 2;
            dl = dl_fix >= 0 ? dl_fix : $urandom_range(0, 2);
          end else bp--;
          if (rnd_stray && $urandom_range(0, 3) == 0) mem_data_ok = 1;
        end else if (phase == 2) begin
          if (dl == 0) begin
            mem_data_ok = 1; mem_rdata = acc_addr ^ K; real_resp = 1; phase = 0;
          end else dl--;
        end else if (rnd_stray && $urandom_range(0, 3) == 0) mem_data_ok = 1;
      end
    end
  end

  // grant model: alternate on ties, one transaction at a time; pushes expectations
  initial begin
    bit m_last, m_busy;
    logic [1:0] ew;
    mexp_t te;
    rexp_t tr;
    m_last = 0; m_busy = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_outputs", {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
            mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}, '0);
        mem_q.delete(); rsp_q.delete(); m_last = 0; m_busy = 0;
      end else begin
        ew = 2'b00;
        if (!m_busy && (inst_req || data_req))
          ew = (inst_req && data_req) ? (m_last ? 2'b01 : 2'b10) : {data_req, inst_req};
        chk("grant", {data_addr_ok, inst_addr_ok}, ew);
        if (ew != 2'b00) begin
          te.own = ew[1];
          te.wr = ew[1] ? data_wr : 1'b0;
          te.wstrb = ew[1] ? data_wstrb : 4'h0;
          te.addr = ew[1] ? data_addr : inst_addr;
          te.wdata = ew[1] ? data_wdata : 32'h0;
          tr.own = ew[1];
          tr.rdata = te.addr ^ K;
          mem_q.push_back(te); rsp_q.push_back(tr);
          m_last = ew[1]; m_busy = 1;
        end
        if (real_resp) m_busy = 0;
      end
    end
  end

  // memory-side monitor: first request cycle matches grant, later cycles stay stable
  initial begin
    bit m_in;
    mexp_t me;
    logic [68:0] snap;
    m_in = 0; snap = 0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req) m_in = 0;
      else begin
        if (!m_in) begin
          chk("mem_expected", mem_q.size() != 0, 1);
          if (mem_q.size() != 0) begin
            me = mem_q.pop_front();
            chk("mem_fields", {mem_wr, mem_wstrb, mem_addr, me.own ? mem_wdata : 32'h0},
                {me.wr, me.wstrb, me.addr, me.wdata});
          end
          snap = {mem_wr, mem_wstrb, mem_addr, mem_wdata};
          m_in = 1;
        end else chk("mem_stable", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, snap);
        if (mem_addr_ok) m_in = 0;
      end
    end
  end

  // response monitor: data_ok only when memory really answers, routed to owner
  initial begin
    rexp_t re;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (real_resp) begin
          chk("rsp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            re = rsp_q.pop_front();
            chk("rsp", {inst_data_ok, data_data_ok, inst_rdata, data_rdata}, {!re.own, re.own, re.rdata, re.rdata});
          end
        end else chk("no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; inst_req = 0; data_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    int n, nd, ni;
    logic pend;
    logic [3:0] got;
    bit ia, da, found;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    // single fetch, minimum latency
    @(posedge clk); #1 inst_req = 1; inst_addr = 32'h1C00_0000;
    @(negedge clk); chk("fetch_c0_addr_ok", inst_addr_ok, 1);
    @(posedge clk); #1 inst_req = 0;
    @(negedge clk); chk("fetch_c1_mem", {mem_req, mem_addr_ok, mem_addr}, {1'b1, 1'b1, 32'h1C00_0000});
    @(negedge clk); chk("fetch_c2_data_ok", {inst_data_ok, inst_rdata}, {1'b1, 32'h0280_0C0C});
    // tie after reset: data, inst, data, inst
    do_reset();
    @(posedge clk); #1 inst_req = 1; data_req = 1; inst_addr = 32'h1C00_0040; data_addr = 32'h200; data_wr = 0;
    n = 0; pend = 0; got = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (inst_data_ok || data_data_ok) pend = 0;
      if (inst_addr_ok || data_addr_ok) begin
        chk("tie_serialised", pend, 0);
        got[n] = data_addr_ok; n++; pend = 1;
      end
    end
    @(posedge clk); #1 inst_req = 0; data_req = 0;
    chk("tie_order", {8'(n), got}, {8'd4, 4'b0101});
    repeat (6) @(negedge clk);
    // store
    @(posedge clk); #1 data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("store_addr_ok", data_addr_ok, 1);
    @(posedge clk); #1 data_req = 0; data_wr = 0;
    @(negedge clk); chk("store_mem", {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF});
    nd = 0; ni = 0;
    repeat (4) begin
      @(negedge clk); nd += int'(data_data_ok); ni += int'(inst_data_ok);
    end
    chk("store_data_ok_once", {8'(nd), 8'(ni)}, {8'd1, 8'd0});
    // back-pressure: five cycles without mem_addr_ok
    bp_fix = 5;
    @(posedge clk); #1 inst_req = 1; inst_addr = 32'h2000;
    @(negedge clk); chk("bp_addr_ok", inst_addr_ok, 1);
    @(posedge clk); #1 inst_req = 0; data_req = 1; data_addr = 32'h3000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_stable", {mem_req, mem_addr_ok, mem_addr, mem_wr, inst_addr_ok, data_addr_ok}, {1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b0});
    end
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); found = data_addr_ok;
    end
    chk("bp_then_data_grant", found, 1);
    @(posedge clk); #1 data_req = 0; bp_fix = 0;
    repeat (6) @(negedge clk);
    // stray responses in IDLE, in REQ, and together with mem_addr_ok
    @(posedge clk); #1 force_stray = 1;
    @(negedge clk); chk("stray_idle", {mem_req, inst_data_ok, data_data_ok}, 3'b000);
    @(posedge clk); #1 force_stray = 0; bp_fix = 2; dl_fix = 1; inst_req = 1; inst_addr = 32'h4000;
    @(posedge clk); #1 inst_req = 0; force_stray = 1;
    @(negedge clk); chk("stray_req", {mem_req, mem_addr_ok, inst_data_ok, data_data_ok}, 4'b1000);
    @(posedge clk); #1 force_stray = 0;
    @(posedge clk); #1 force_stray = 1;
    @(negedge clk); chk("stray_with_addr_ok", {mem_req, mem_addr_ok, inst_data_ok, data_data_ok}, 4'b1100);
    @(posedge clk); #1 force_stray = 0;
    @(negedge clk); chk("stray_resp_wait", {mem_req, inst_data_ok}, 2'b00);
    @(negedge clk); chk("stray_then_data_ok", inst_data_ok, 1);
    repeat (4) @(negedge clk);
    // reset during RESP, stray response afterwards, data wins next tie
    bp_fix = 0; dl_fix = 3;
    @(posedge clk); #1 inst_req = 1; inst_addr = 32'h5000;
    @(posedge clk); #1 inst_req = 0;
    @(posedge clk); #1 reset = 1; inst_req = 1; data_req = 1; data_addr = 32'h600;
    @(negedge clk); chk("rst_resp_zero", {inst_data_ok, data_data_ok, mem_req, inst_addr_ok, data_addr_ok}, 5'b0);
    @(posedge clk); #1 force_stray = 1;
    @(negedge clk); chk("rst_stray", {inst_data_ok, data_data_ok}, 2'b00);
    @(posedge clk); #1 reset = 0;
    @(negedge clk); chk("rst_tie_data", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0100);
    @(posedge clk); #1 force_stray = 0; inst_req = 0; data_req = 0; dl_fix = -1; bp_fix = -1;
    repeat (10) @(negedge clk);
    // randomized traffic
    rnd_stray = 1; ia = 0; da = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (!inst_req || ia) begin
        inst_req = $urandom_range(0, 2) != 0;
        inst_addr = $urandom & ~32'h3;
      end
      if (!data_req || da) begin
        data_req = $urandom_range(0, 2) != 0;
        data_wr = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom);
        data_addr = $urandom & ~32'h3;
        data_wdata = $urandom;
      end
      @(negedge clk); ia = inst_addr_ok; da = data_addr_ok;
    end
    @(posedge clk); #1 inst_req = 0; data_req = 0; rnd_stray = 0;
    repeat (12) @(negedge clk);
    chk("drain", 32'(mem_q.size() + rsp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
